de0qsys_led: RTL and testbench

DE0QSYS_LED -- requirements
Module: de0qsys_led

---
 rtl/de0qsys_led.sv | 113 +++++++++++
 tb/tb_de0qsys_led.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de0qsys_led.sv
// Avalon-MM LED output port with a per-bit blink mask driven by a programmable half-period timer.
// Registers: data, blink_mask, period, status (phase), plus write-only set/clear strobes.
module de0qsys_led #(
  parameter int unsigned           DATA_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrMask     = 3'd1;
  localparam logic [2:0] AddrPeriod   = 3'd2;
  localparam logic [2:0] AddrStatus   = 3'd3;
  localparam logic [2:0] AddrOutset   = 3'd4;
  localparam logic [2:0] AddrOutclear = 3'd5;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [15:0]           period_q, period_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [15:0]           wperiod;

  assign wr_en   = chipselect & ~write_n;
  assign wdata   = writedata[DATA_WIDTH-1:0];
  assign wperiod = writedata[15:0];

  // Upper write-data bits are architecturally ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // Register-file writes; status and reserved addresses fall through untouched.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        AddrData:     data_d   = wdata;
        AddrMask:     mask_d   = wdata;
        AddrPeriod:   period_d = wperiod;
        AddrOutset:   data_d   = data_q | wdata;
        AddrOutclear: data_d   = data_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // Blink timer: cnt runs period..0 then reloads, so phase flips every period+1 clocks.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && (address == AddrPeriod)) begin
      cnt_d = wperiod;
      if (wperiod == 16'd0) begin
        phase_d = 1'b0;
      end
    end else if (period_q == 16'd0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == 16'd0) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Read mux samples pre-write values; registered unconditionally for a fixed latency of 1.
  always_comb begin
    rdata_d = '0;
    case (address)
      AddrData:   rdata_d[DATA_WIDTH-1:0] = data_q;
      AddrMask:   rdata_d[DATA_WIDTH-1:0] = mask_q;
      AddrPeriod: rdata_d[15:0]           = period_q;
      AddrStatus: rdata_d[0]              = phase_q;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});

endmodule

// File: tb/tb_de0qsys_led.sv
// Randomized + directed bench for de0qsys_led against a time-based behavioural model.
module tb_de0qsys_led;

  localparam int unsigned DW    = 10;
  localparam logic [31:0] DMASK = 32'h0000_03FF;

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  int n_chk;
  int n_fail;
  bit en_cmp;

  de0qsys_led #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE ('0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Model: phase is derived from elapsed clocks since the last period write.
  logic [31:0] m_data;
  logic [31:0] m_mask;
  int          m_period;
  logic        m_phase0;
  longint      m_k;
  logic [31:0] m_rd;

  function automatic logic phase_now();
    if (m_period == 0) return 1'b0;
    return m_phase0 ^ (((m_k / (longint'(m_period) + 1)) % 2) == 1);
  endfunction

  function automatic logic [31:0] model_out();
    return (m_data ^ (m_mask & {32{phase_now()}})) & DMASK;
  endfunction

  function automatic logic [31:0] rd_model(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return m_mask;
      3'd2:    return 32'(m_period);
      3'd3:    return {31'b0, phase_now()};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data   <= 32'h0;
      m_mask   <= 32'h0;
      m_period <= 0;
      m_phase0 <= 1'b0;
      m_k      <= 0;
      m_rd     <= 32'h0;
    end else begin
      m_rd <= rd_model(address);
      m_k  <= m_k + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata & DMASK;
          3'd1: m_mask <= writedata & DMASK;
          3'd2: begin
            m_period <= int'(writedata[15:0]);
            m_k      <= 0;
            m_phase0 <= (writedata[15:0] == 16'd0) ? 1'b0 : phase_now();
          end
          3'd4: m_data <= (m_data | writedata) & DMASK;
          3'd5: m_data <= m_data & ~writedata & DMASK;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en_cmp) begin
      check("out_port vs model", 32'(out_port), model_out());
      check("readdata vs model", readdata, m_rd);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic        s0;
    int          c;
    clk        = 1'b0;
    reset_n    = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    n_chk      = 0;
    n_fail     = 0;
    en_cmp     = 1'b0;

    #1 reset_n = 1'b0;
    #1;
    check("reset out_port", 32'(out_port), 32'h0);
    check("reset readdata", readdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    en_cmp = 1'b1;

    rd(3'd0, v);
    check("read data after reset", v, 32'h0);
    check("out_port after reset", 32'(out_port), 32'h0);

    wr(3'd0, 32'h2A5);
    rd(3'd0, v);
    check("read data 0x2A5", v, 32'h2A5);
    check("out_port 0x2A5", 32'(out_port), 32'h2A5);
    wr(3'd0, 32'hFFFF_F000);
    check("upper bits ignored", 32'(out_port), 32'h0);
    rd(3'd0, v);
    check("read data 0 after upper write", v, 32'h0);

    wr(3'd0, 32'h0F0);
    wr(3'd4, 32'h003);
    check("outset", 32'(out_port), 32'h0F3);
    wr(3'd5, 32'h030);
    check("outclear", 32'(out_port), 32'h0C3);
    rd(3'd4, v);
    check("read outset", v, 32'h0);
    rd(3'd5, v);
    check("read outclear", v, 32'h0);

    // Period 3: bit0 of out_port flips every 4 clocks; data bit0 is 1.
    wr(3'd1, 32'h001);
    wr(3'd2, 32'h003);
    check("blink c0", 32'(out_port[0]), 32'h1);
    address = 3'd3;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk);
      #1;
      check("blink out bit0", 32'(out_port[0]), ((k / 4) % 2 == 1) ? 32'h0 : 32'h1);
      check("blink status", readdata, (((k - 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
    end
    wr(3'd2, 32'h0);
    check("blink off out_port", 32'(out_port), 32'h0C3);
    rd(3'd3, v);
    check("blink off status", v, 32'h0);

    // Maximum period: first toggle 65536 clocks after the write.
    wr(3'd2, 32'hFFFF);
    s0 = out_port[0];
    c  = 0;
    for (int k = 1; k <= 70000; k++) begin
      @(posedge clk);
      #1;
      if (out_port[0] != s0) begin
        c = k;
        break;
      end
    end
    check("period FFFF first toggle", 32'(c), 32'd65536);

    // Reset mid-blink while phase is 1.
    wr(3'd2, 32'h2);
    c = 0;
    for (int k = 0; k < 20; k++) begin
      if (phase_now()) begin
        c = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("reached phase 1", 32'(c), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset out_port", 32'(out_port), 32'h0);
    check("async reset readdata", readdata, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(3'(a), v);
      check("read after reset", v, 32'h0);
    end

    // Randomized traffic with small periods and occasional reset pulses.
    for (int k = 0; k < 3000; k++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      writedata  = $urandom;
      if (address == 3'd2) begin
        writedata[15:0] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
    end

    en_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
